uart_rom_loader: RTL
====================

Name: uart_rom_loader

Overview:
- Boot loader upstream of the CPU's instruction ROM on the mother board.
- Receives a program over uart_rx and writes it word-by-word into the ROM.
- Holds the CPU in reset-like hold until the image is complete, then releases it.
- Bit timing uses the same WAIT clocks-per-bit convention as the board's UART.

Parameters:
- WAIT, 8: clock cycles per UART bit; must be ≥4 and even.
- DEPTH, 16: ROM depth in 32-bit words.
- ADDR_W, 4: ROM word-address width; must equal clog2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- uart_rx  input  1  serial input; idle high, 8N1, LSB first.
- rom_we  output  1  one-cycle ROM write strobe.
- rom_addr  output  ADDR_W  ROM word index for the write.
- rom_wdata  output  32  ROM write data.
- cpu_hold  output  1  high while the image is incomplete; CPU must not fetch.
- load_done  output  1  one-cycle pulse when the image is complete.
- frame_err  output  1  sticky; set on any bad stop bit or false start.

Behaviour:
- Reset (reset=0, async), all outputs and state:
  - rom_we=0, rom_addr=0, rom_wdata=0, cpu_hold=1, load_done=0, frame_err=0.
  - FSM in S_LEN0; synchronizer flops preset to 1 (idle).
- uart_rx input:
  - Passes through a 2-flop synchronizer; "rxs" is the synchronized value.
  - All receiver timing below is in cycles relative to rxs.
- Byte receiver:
  - Idle: first cycle with rxs=0 is t0.
  - At t0+WAIT/2: rxs must still be 0, otherwise it is a false start → frame_err=1 and return to idle.
  - Data bit k (k=0..7) is sampled at t0+WAIT/2+(k+1)*WAIT.
  - Stop bit is sampled at t0+WAIT/2+9*WAIT.
  - Stop=1: rx_valid pulses for 1 cycle the next cycle, with rx_byte.
  - Stop=0: byte is discarded, frame_err=1, and the loader error event fires.
  - Receiver returns to idle immediately after the stop sample. A new start may begin the following cycle.
- Loader FSM, advanced on each rx_valid:
  - S_LEN0: len[7:0] = byte → S_LEN1.
  - S_LEN1: len[15:8] = byte. If len==0 → S_DONE; else clear word count and byte index → S_DATA.
  - S_DATA: bytes are assembled little-endian into a 32-bit word (byte index 0..3).
    - On the 4th byte, the next cycle asserts rom_we=1 with rom_addr = word count[ADDR_W-1:0] and the assembled word.
    - rom_we is suppressed when word count ≥ DEPTH; the byte is still consumed.
    - word count increments on the 4th byte. When word count reaches len → S_DONE.
  - S_DONE: cpu_hold=0. Further bytes are ignored. Only reset leaves this state.
- load_done:
  - Pulses 1 cycle on the cycle after the final rom_we; cpu_hold falls on that same cycle.
  - For len==0: load_done pulses on the cycle after the second length byte's rx_valid.
- Error event in any state except S_DONE: FSM returns to S_LEN0, counters cleared, cpu_hold stays 1, frame_err stays 1.
  - Errors in S_DONE set frame_err only.
- rom_addr and rom_wdata hold their last values when rom_we=0.
- Widths:
  - Word count is 16 bits and never wraps (len ≤ 65535).
  - Byte index is 2 bits.

Decomposition:
- Shared package holds:
  - typedef loader_state_t {S_LEN0, S_LEN1, S_DATA, S_DONE};
  - constants UART_DATA_BITS=8 and BYTES_PER_WORD=4.
- One sub-module, uart_rx_byte: synchronizer, bit timing, and rx_valid/rx_byte/rx_err outputs.
- uart_rom_loader contains the FSM, assembly register and counters.

Test Plan:
All scenarios use WAIT=8, DEPTH=16.
- Reset check: reset=0 → outputs 0, 0, 0, 1, 0, 0. Release with uart_rx=1 for 200 cycles → no rom_we, cpu_hold stays 1.
- Two-word load: bytes 02 00 | 01 00 10 00 | 0A 00 00 00 →
  - rom writes addr0=0x00100001, then addr1=0x0000000A;
  - exactly two rom_we pulses;
  - load_done one cycle after the 2nd write; cpu_hold=0 thereafter.
- Zero length: bytes 00 00 → load_done one cycle after the 2nd rx_valid, no rom_we, cpu_hold=0. Extra byte FF afterwards → no effect.
- Framing error: send 02 00, then a byte whose stop bit is 0 → frame_err=1 and FSM in S_LEN0. Then a full valid 1-word image 01 00 78 56 34 12 → addr0=0x12345678, load_done, frame_err still 1.
- Overflow: len 18 (12 00) followed by 72 bytes → 16 writes at addr 0..15, words 17 and 18 produce no rom_we, load_done after the 72nd byte.
- Reset mid-load: assert reset during the 3rd data byte → outputs return to reset values immediately. After release, a fresh 1-word image loads correctly at addr0.

Source files
------------

// File: rtl/uart_rom_loader_pkg.sv
// Shared definitions for the UART boot loader.
//   UART_DATA_BITS  : data bits per UART frame (8N1)
//   BYTES_PER_WORD  : bytes assembled into one 32-bit ROM word
//   loader_state_t  : loader FSM states
//   rx_state_t      : byte receiver FSM states
package uart_rom_loader_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_DONE
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// UART 8N1 byte receiver with a 2-flop input synchronizer.
// Ports:
//   i_clk       system clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_uart_rx   serial input, idle high, LSB first
//   o_rx_valid  one-cycle pulse, cycle after a good stop bit
//   o_rx_byte   received byte, valid with o_rx_valid
//   o_rx_err    one-cycle pulse on a bad (low) stop bit
//   o_rx_fs     one-cycle pulse on a false start
module uart_rx_byte #(
    parameter int WAIT = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_uart_rx,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_err,
    output logic       o_rx_fs
);
    import uart_rom_loader_pkg::*;

    localparam int              CNT_W    = $clog2(WAIT + 1);
    localparam logic [CNT_W-1:0] HALF    = CNT_W'(WAIT / 2);
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(WAIT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

    logic [1:0]       r_sync;
    logic             w_rxs;
    rx_state_t        r_state;
    rx_state_t        w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_valid;
    logic [7:0]       r_byte;
    logic             r_err;
    logic             r_fs;
    logic             w_hit_half;
    logic             w_hit_bit;

    assign w_rxs      = r_sync[1];
    assign w_hit_half = (r_cnt == HALF);
    assign w_hit_bit  = (r_cnt == FULL);
    assign o_rx_valid = r_valid;
    assign o_rx_byte  = r_byte;
    assign o_rx_err   = r_err;
    assign o_rx_fs    = r_fs;

    // Synchronizer presets to idle-high so reset never looks like a start bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sync <= 2'b11;
        else          r_sync <= {r_sync[0], i_uart_rx};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= RX_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            RX_IDLE:  if (!w_rxs) w_next = RX_START;
            RX_START: if (w_hit_half) w_next = w_rxs ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_hit_bit && (r_bit == LAST_BIT)) w_next = RX_STOP;
            RX_STOP:  if (w_hit_bit) w_next = RX_IDLE;
            default:  w_next = RX_IDLE;
        endcase
    end

    // r_cnt equals the number of cycles elapsed since the last reference
    // point (t0, then each sample), so every sample lands on r_cnt == target.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_valid <= 1'b0;
            r_byte  <= '0;
            r_err   <= 1'b0;
            r_fs    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_fs    <= 1'b0;
            case (r_state)
                RX_IDLE: r_cnt <= ONE;
                RX_START: begin
                    if (w_hit_half) begin
                        r_cnt <= ONE;
                        r_bit <= '0;
                        r_fs  <= w_rxs;
                    end else begin
                        r_cnt <= r_cnt + ONE;
                    end
                end
                RX_DATA: begin
                    if (w_hit_bit) begin
                        r_cnt   <= ONE;
                        r_shift <= {w_rxs, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                    end else begin
                        r_cnt <= r_cnt + ONE;
                    end
                end
                RX_STOP: begin
                    if (w_hit_bit) begin
                        r_valid <= w_rxs;
                        r_err   <= ~w_rxs;
                        if (w_rxs) r_byte <= r_shift;
                    end else begin
                        r_cnt <= r_cnt + ONE;
                    end
                end
                default: r_cnt <= ONE;
            endcase
        end
    end

endmodule

// File: rtl/uart_rom_loader.sv
// Boot loader: receives a length-prefixed program over UART and writes it
// word-by-word (little-endian) into the CPU instruction ROM, holding the CPU
// until the image is complete.
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   uart_rx    serial input, idle high, 8N1, LSB first
//   rom_we     one-cycle ROM write strobe
//   rom_addr   ROM word index for the write
//   rom_wdata  ROM write data
//   cpu_hold   high while the image is incomplete
//   load_done  one-cycle pulse when the image is complete
//   frame_err  sticky framing / false-start flag
module uart_rom_loader #(
    parameter int WAIT   = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [31:0]       rom_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              frame_err
);
    import uart_rom_loader_pkg::*;

    localparam logic [15:0] DEPTH16   = 16'(DEPTH);
    localparam logic [1:0]  LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic          w_rx_valid;
    logic [7:0]    w_rx_byte;
    logic          w_rx_err;
    logic          w_rx_fs;
    logic          w_err_evt;
    loader_state_t r_state;
    loader_state_t w_next;
    logic [15:0]   r_len;
    logic [15:0]   r_wcnt;
    logic [1:0]    r_bidx;
    logic [31:0]   r_asm;
    logic          r_last;
    logic          r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]   r_wdata;
    logic          r_done;
    logic          r_ferr;

    uart_rx_byte #(.WAIT(WAIT)) u_rx (
        .i_clk      (clk),
        .i_rst_n    (reset),
        .i_uart_rx  (uart_rx),
        .o_rx_valid (w_rx_valid),
        .o_rx_byte  (w_rx_byte),
        .o_rx_err   (w_rx_err),
        .o_rx_fs    (w_rx_fs)
    );

    // A bad stop bit aborts the load unless the image is already complete.
    assign w_err_evt = w_rx_err && (r_state != S_DONE);

    assign rom_we    = r_we;
    assign rom_addr  = r_addr;
    assign rom_wdata = r_wdata;
    assign cpu_hold  = (r_state != S_DONE);
    assign load_done = r_done;
    assign frame_err = r_ferr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_LEN0;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_err_evt) begin
            w_next = S_LEN0;
        end else begin
            case (r_state)
                S_LEN0: if (w_rx_valid) w_next = S_LEN1;
                S_LEN1: if (w_rx_valid)
                            w_next = ({w_rx_byte, r_len[7:0]} == 16'd0) ? S_DONE : S_DATA;
                // r_last is set with the final write, so DONE follows that write.
                S_DATA: if (r_last) w_next = S_DONE;
                S_DONE: w_next = S_DONE;
                default: w_next = S_LEN0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_len   <= '0;
            r_wcnt  <= '0;
            r_bidx  <= '0;
            r_asm   <= '0;
            r_last  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_last <= 1'b0;
            r_done <= (r_state != S_DONE) && (w_next == S_DONE);
            if (w_rx_err || w_rx_fs) r_ferr <= 1'b1;

            if (w_err_evt) begin
                r_wcnt <= '0;
                r_bidx <= '0;
            end else if (w_rx_valid) begin
                case (r_state)
                    S_LEN0: r_len[7:0] <= w_rx_byte;
                    S_LEN1: begin
                        r_len[15:8] <= w_rx_byte;
                        r_wcnt      <= '0;
                        r_bidx      <= '0;
                    end
                    S_DATA: begin
                        r_asm  <= {w_rx_byte, r_asm[31:8]};
                        r_bidx <= r_bidx + 2'd1;
                        if (r_bidx == LAST_BYTE) begin
                            // Words beyond the ROM are consumed but not written.
                            if (r_wcnt < DEPTH16) begin
                                r_we    <= 1'b1;
                                r_addr  <= r_wcnt[ADDR_W-1:0];
                                r_wdata <= {w_rx_byte, r_asm[31:8]};
                            end
                            r_wcnt <= r_wcnt + 16'd1;
                            r_last <= ((r_wcnt + 16'd1) == r_len);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
